pixel_mem_arbiter: RTL and testbench

Shares the single 48-bit (two-pixel) frame memory read port between two requesters: port 0 (display pixel fetch, high priority) and port 1 (host/debug readback, low priority). Uses a per-port request/grant handshake, issues one read at a time to the memory and returns the word with a valid pulse. Fixed priority to port 0, with a starvation limit that forces a port-1 grant.

---
 rtl/pixel_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_pixel_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mem_arbiter.sv
// Two-port read arbiter for the 48-bit frame memory port.
// Display fetch has priority; host readback gets a forced grant after a starvation limit.
`timescale 1ns/1ps
module pixel_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 48,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  output logic              GNT0,
  output logic              VALID0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  output logic              GNT1,
  output logic              VALID1,
  output logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_EN,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [2:0] LAT  = 3'(MEM_LAT);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              owner_nxt;
  logic [3:0]        starve;
  logic [3:0]        starve_nxt;
  logic [2:0]        lat;
  logic [2:0]        lat_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_nxt;

  logic arb;
  logic any_req;
  logic win;

  assign any_req = REQ0 | REQ1;
  assign arb     = (state == IDLE) || (state == DELIVER);

  // Port 1 wins alone, or when both ask and it has waited long enough
  assign win = REQ1 && (!REQ0 || (starve == SMAX));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      owner   <= 1'b0;
      starve  <= '0;
      lat     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      starve  <= starve_nxt;
      lat     <= lat_nxt;
      addr_q  <= addr_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve;
    lat_nxt    = lat;
    addr_nxt   = addr_q;
    rdata_nxt  = rdata_q;
    unique case (state)
      IDLE, DELIVER: begin
        if (any_req) begin
          state_nxt = ISSUE;
          owner_nxt = win;
          addr_nxt  = win ? ADDR1 : ADDR0;
        end else begin
          state_nxt = IDLE;
        end
        if (any_req && !win && REQ1) begin
          starve_nxt = (starve == SMAX) ? SMAX : starve + 4'd1;
        end else begin
          starve_nxt = '0;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        lat_nxt   = LAT;
      end
      WAIT: begin
        if (lat == 3'd1) begin
          state_nxt = DELIVER;
          rdata_nxt = MEM_DATA;
        end else begin
          lat_nxt = lat - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    GNT0   = 1'b0;
    GNT1   = 1'b0;
    VALID0 = 1'b0;
    VALID1 = 1'b0;
    MEM_EN = 1'b0;
    BUSY   = (state != IDLE);
    if (state == ISSUE) begin
      MEM_EN = 1'b1;
      GNT0   = !owner;
      GNT1   = owner;
    end
    if (state == DELIVER) begin
      VALID0 = !owner;
      VALID1 = owner;
    end
  end

  assign MEM_ADDR = addr_q;
  assign RDATA    = rdata_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Scoreboard bench for pixel_mem_arbiter: MEM_LAT=1 main instance,
// MEM_LAT=3 instance for the long-latency case.
`timescale 1ns/1ps
module tb_pixel_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ0, REQ1;
  logic [15:0] ADDR0, ADDR1;
  logic        GNT0, GNT1, VALID0, VALID1, MEM_EN, BUSY;
  logic [47:0] RDATA, MEM_DATA;
  logic [15:0] MEM_ADDR;

  logic        REQ0_3, REQ1_3;
  logic [15:0] ADDR0_3, ADDR1_3;
  logic        GNT0_3, GNT1_3, VALID0_3, VALID1_3, MEM_EN_3, BUSY_3;
  logic [47:0] RDATA_3, MEM_DATA_3;
  logic [15:0] MEM_ADDR_3;

  always #5 CLK = ~CLK;

  pixel_mem_arbiter #(.ADDR_W(16), .DATA_W(48), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .ADDR0(ADDR0), .GNT0(GNT0), .VALID0(VALID0),
    .REQ1(REQ1), .ADDR1(ADDR1), .GNT1(GNT1), .VALID1(VALID1),
    .RDATA(RDATA), .MEM_ADDR(MEM_ADDR), .MEM_EN(MEM_EN),
    .MEM_DATA(MEM_DATA), .BUSY(BUSY)
  );

  pixel_mem_arbiter #(.ADDR_W(16), .DATA_W(48), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0_3), .ADDR0(ADDR0_3), .GNT0(GNT0_3), .VALID0(VALID0_3),
    .REQ1(REQ1_3), .ADDR1(ADDR1_3), .GNT1(GNT1_3), .VALID1(VALID1_3),
    .RDATA(RDATA_3), .MEM_ADDR(MEM_ADDR_3), .MEM_EN(MEM_EN_3),
    .MEM_DATA(MEM_DATA_3), .BUSY(BUSY_3)
  );

  function automatic logic [47:0] mem_f(input logic [15:0] a);
    if (a == 16'h0010) return 48'hAAAA_BBBB_CCCC;
    return {a ^ 16'h1234, ~a, a + 16'h0101};
  endfunction

  // Memory models: data is only meaningful exactly MEM_LAT cycles after MEM_EN
  logic        m1_v = 1'b0;
  logic [15:0] m1_a = '0;
  always @(posedge CLK) begin
    m1_v <= MEM_EN;
    m1_a <= MEM_ADDR;
  end
  assign MEM_DATA = m1_v ? mem_f(m1_a) : 48'hDEAD_0BAD_F00D;

  logic [2:0]  m3_v = '0;
  logic [15:0] m3_a0 = '0, m3_a1 = '0, m3_a2 = '0;
  always @(posedge CLK) begin
    m3_v  <= {m3_v[1:0], MEM_EN_3};
    m3_a0 <= MEM_ADDR_3;
    m3_a1 <= m3_a0;
    m3_a2 <= m3_a1;
  end
  assign MEM_DATA_3 = m3_v[2] ? mem_f(m3_a2) : 48'hDEAD_0BAD_F00D;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int unexp = 0;
  int excl_bad = 0;
  int bad3 = 0;
  int nv, drops, tw;
  logic vseen;

  logic [15:0] qa0[$], qa1[$];
  logic [47:0] qd0[$], qd1[$];
  int glog[$];
  int ecyc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (GNT0) begin
        glog.push_back(0);
        if (qa0.size() == 0) unexp++;
        else chk("gnt0_addr", 64'(MEM_ADDR), 64'(qa0.pop_front()));
      end
      if (GNT1) begin
        glog.push_back(1);
        if (qa1.size() == 0) unexp++;
        else chk("gnt1_addr", 64'(MEM_ADDR), 64'(qa1.pop_front()));
      end
      if (MEM_EN) ecyc.push_back(cyc);
      if (VALID0) begin
        if (qd0.size() == 0) unexp++;
        else chk("rdata0", 64'(RDATA), 64'(qd0.pop_front()));
      end
      if (VALID1) begin
        if (qd1.size() == 0) unexp++;
        else chk("rdata1", 64'(RDATA), 64'(qd1.pop_front()));
      end
      if ((GNT0 && GNT1) || (VALID0 && VALID1) || (MEM_EN != (GNT0 | GNT1)))
        excl_bad++;
    end
  end

  task automatic set_req(input int p, input logic v, input logic [15:0] a);
    if (p == 0) begin
      REQ0 = v;
      if (v) ADDR0 = a;
    end else begin
      REQ1 = v;
      if (v) ADDR1 = a;
    end
  endtask

  task automatic push(input int p, input logic [15:0] a);
    if (p == 0) begin
      qa0.push_back(a);
      qd0.push_back(mem_f(a));
    end else begin
      qa1.push_back(a);
      qd1.push_back(mem_f(a));
    end
  endtask

  // kind 0 waits for GNTp, kind 1 for VALIDp
  task automatic wait_sig(input int p, input int kind);
    int t = 0;
    logic hit;
    do begin
      @(negedge CLK);
      t++;
      if (kind == 0) hit = (p == 0) ? GNT0 : GNT1;
      else hit = (p == 0) ? VALID0 : VALID1;
    end while (!hit && t < 60);
    chk($sformatf("wait_p%0d_k%0d", p, kind), 64'(hit), 64'd1);
  endtask

  task automatic run_port(input int p, input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) wait_sig(p, 1);
      set_req(p, 1'b1, base + 16'(i));
      push(p, base + 16'(i));
      wait_sig(p, 0);
      set_req(p, 1'b0, '0);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic check_order(input string tag, input int exp_o[]);
    chk({tag, "_len"}, 64'(glog.size()), 64'(exp_o.size()));
    for (int i = 0; i < exp_o.size() && i < glog.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(glog[i]), 64'(exp_o[i]));
    for (int i = 1; i < ecyc.size(); i++)
      chk($sformatf("%s_gap%0d", tag, i), 64'(ecyc[i] - ecyc[i-1]), 64'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0; ADDR0 = '0; ADDR1 = '0;
    REQ0_3 = 1'b0; REQ1_3 = 1'b0; ADDR0_3 = '0; ADDR1_3 = '0;
    repeat (2) @(negedge CLK);
    chk("rst_outs", 64'({GNT0, GNT1, VALID0, VALID1, MEM_EN, BUSY}), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_addr", 64'(MEM_ADDR), 64'd0);
    chk("rst_outs3", 64'({GNT0_3, GNT1_3, VALID0_3, VALID1_3, MEM_EN_3, BUSY_3}), 64'd0);
    RESET = 1'b0;

    // single port-0 read, cycle-exact
    set_req(0, 1'b1, 16'h0010);
    push(0, 16'h0010);
    @(negedge CLK);
    chk("t1_c1", 64'({GNT0, MEM_EN, BUSY, VALID0}), 64'b1110);
    chk("t1_addr", 64'(MEM_ADDR), 64'h0010);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("t1_c2", 64'({GNT0, MEM_EN, BUSY, VALID0}), 64'b0010);
    @(negedge CLK);
    chk("t1_c3", 64'({GNT0, MEM_EN, BUSY, VALID0}), 64'b0011);
    chk("t1_rdata", 64'(RDATA), 64'hAAAA_BBBB_CCCC);
    @(negedge CLK);
    chk("t1_c4", 64'({BUSY, VALID0}), 64'd0);

    // MEM_LAT=3, port 1 only
    REQ1_3 = 1'b1;
    ADDR1_3 = 16'h00FF;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      REQ1_3 = 1'b0;
      chk($sformatf("t3_gnt1_c%0d", c), 64'(GNT1_3), 64'(c == 1));
      chk($sformatf("t3_val1_c%0d", c), 64'(VALID1_3), 64'(c == 5));
      if (c == 5) chk("t3_rdata", 64'(RDATA_3), 64'(mem_f(16'h00FF)));
      if (GNT0_3 || VALID0_3) bad3++;
    end
    chk("t3_p0_quiet", 64'(bad3), 64'd0);

    // both ports continuously requesting
    do_reset();
    glog.delete();
    ecyc.delete();
    fork
      run_port(0, 16'h0100, 8);
      run_port(1, 16'h0200, 2);
    join
    repeat (5) @(negedge CLK);
    check_order("t2_order", '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});

    // port 0 back-to-back reads
    do_reset();
    glog.delete();
    ecyc.delete();
    nv = 0;
    drops = 0;
    tw = 0;
    fork
      run_port(0, 16'h0001, 3);
      begin
        while (!GNT0 && tw < 20) begin
          @(negedge CLK);
          tw++;
        end
        while (nv < 3 && tw < 60) begin
          if (!BUSY) drops++;
          if (VALID0) nv++;
          @(negedge CLK);
          tw++;
        end
      end
    join
    repeat (3) @(negedge CLK);
    chk("t4_valids", 64'(nv), 64'd3);
    chk("t4_busy_drops", 64'(drops), 64'd0);
    check_order("t4_order", '{0, 0, 0});

    // reset while waiting on memory
    do_reset();
    set_req(0, 1'b1, 16'h0042);
    qa0.push_back(16'h0042);
    @(negedge CLK);
    REQ0 = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("t5_outs", 64'({GNT0, GNT1, VALID0, VALID1, MEM_EN, BUSY}), 64'd0);
    chk("t5_addr", 64'(MEM_ADDR), 64'd0);
    chk("t5_rdata", 64'(RDATA), 64'd0);
    RESET = 1'b0;
    vseen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      vseen |= VALID0 | VALID1;
    end
    chk("t5_novalid", 64'(vseen), 64'd0);
    run_port(0, 16'h0077, 1);
    repeat (4) @(negedge CLK);

    // REQ1 withdrawn, then reasserted: starvation count restarts
    do_reset();
    glog.delete();
    ecyc.delete();
    fork
      run_port(0, 16'h0300, 8);
      begin
        REQ1 = 1'b1;
        ADDR1 = 16'h0BAD;
        tw = 0;
        while (glog.size() < 2 && tw < 40) begin
          @(negedge CLK);
          tw++;
        end
        REQ1 = 1'b0;
        while (glog.size() < 3 && tw < 40) begin
          @(negedge CLK);
          tw++;
        end
        set_req(1, 1'b1, 16'h0400);
        push(1, 16'h0400);
        wait_sig(1, 0);
        REQ1 = 1'b0;
      end
    join
    repeat (5) @(negedge CLK);
    check_order("t6_order", '{0, 0, 0, 0, 0, 0, 0, 1, 0});

    chk("unexpected_events", 64'(unexp), 64'd0);
    chk("exclusivity", 64'(excl_bad), 64'd0);
    chk("sb_drained", 64'(qa0.size() + qa1.size() + qd0.size() + qd1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
